// File: rtl/barrel_shifter.sv
// 32-bit logarithmic barrel shifter with caller-supplied fill bit and a
// registered result (one-cycle latency, one result per cycle).
module barrel_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  input  logic        dir,
  input  logic        feedinbit,
  output logic [31:0] out
);

  // One log-shifter stage: shift by a fixed step toward MSB (dir=0) or LSB
  // (dir=1), filling every vacated position with the fill bit.
  function automatic logic [31:0] shift_stage(
    input logic [31:0] v,
    input int          step,
    input logic        right,
    input logic        fill
  );
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      if (right) begin
        r[i] = (i + step <= 31) ? v[i + step] : fill;
      end else begin
        r[i] = (i >= step) ? v[i - step] : fill;
      end
    end
    return r;
  endfunction

  logic [31:0] stage_s [0:5];
  logic [31:0] out_r;

  assign stage_s[0] = in;

  genvar k;
  generate
    for (k = 0; k < 5; k++) begin : g_stage
      assign stage_s[k+1] = shamt[k] ? shift_stage(stage_s[k], (1 << k), dir, feedinbit)
                                     : stage_s[k];
    end
  endgenerate

  // Result register; reset forces a known zero regardless of input history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= 32'h0000_0000;
    end else begin
      out_r <= stage_s[5];
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed table, pipelining and
// mid-stream reset sequences, then randomized vectors against a reference model.
module tb_barrel_shifter;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic        dir;
  logic        fib;
  logic [31:0] out;

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] in;
    logic [4:0]  shamt;
    logic        dir;
    logic        fill;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  barrel_shifter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (din),
    .shamt     (shamt),
    .dir       (dir),
    .feedinbit (fib),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain shift operators plus a fill mask over the vacated bits.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int s,
                                            input logic d, input logic f);
    logic [31:0] ones;
    logic [31:0] mask;
    ones = 32'hFFFF_FFFF;
    mask = d ? ~(ones >> s) : ~(ones << s);
    return (d ? (v >> s) : (v << s)) | (f ? mask : 32'h0000_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] v, input logic [4:0] s, input logic d, input logic f);
    din   = v;
    shamt = s;
    dir   = d;
    fib   = f;
  endtask

  logic [31:0] prev;
  logic [31:0] rv;
  logic [4:0]  rs;
  logic        rd;
  logic        rf;

  initial begin
    vectors     = 0;
    miscompares = 0;

    tbl[0] = '{32'hB652_5124, 5'd23, 1'b1, 1'b0, 32'h0000_016C};
    tbl[1] = '{32'h9456_59AF, 5'd12, 1'b0, 1'b1, 32'h659A_FFFF};
    tbl[2] = '{32'h305E_5142, 5'd7,  1'b0, 1'b0, 32'h2F28_A100};
    tbl[3] = '{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF};
    tbl[4] = '{32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001};
    tbl[5] = '{32'h1234_5678, 5'd0,  1'b0, 1'b1, 32'h1234_5678};
    tbl[6] = '{32'h1234_5678, 5'd0,  1'b1, 1'b1, 32'h1234_5678};
    tbl[7] = '{32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000};

    // Reset held from time zero with all-ones operand.
    rst_n = 1'b0;
    drive(32'hFFFF_FFFF, 5'd5, 1'b0, 1'b0);
    #2;
    check("reset_no_clock", out, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", out, 32'h0000_0000);
    rst_n = 1'b1;

    // Directed table; also confirm out holds until the next edge.
    prev = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].in, tbl[i].shamt, tbl[i].dir, tbl[i].fill);
      #1;
      check("hold_before_edge", out, prev);
      @(posedge clk);
      #1;
      check($sformatf("table_%0d", i), out, tbl[i].exp);
      prev = tbl[i].exp;
    end

    // Back-to-back vectors: each result on its own successive edge.
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i].in, tbl[i].shamt, tbl[i].dir, tbl[i].fill);
      @(posedge clk);
      #1;
      check($sformatf("pipe_%0d", i), out, tbl[i].exp);
    end

    // Reset pulse between edges discards the in-flight result.
    drive(tbl[0].in, tbl[0].shamt, tbl[0].dir, tbl[0].fill);
    @(posedge clk);
    #1;
    check("pre_midreset", out, tbl[0].exp);
    drive(tbl[1].in, tbl[1].shamt, tbl[1].dir, tbl[1].fill);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_async", out, 32'h0000_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_midreset", out, tbl[1].exp);

    // Randomized vectors, including SRA-style fill from the sign bit.
    for (int i = 0; i < 300; i++) begin
      rv = $urandom;
      rs = 5'($urandom_range(0, 31));
      rd = 1'($urandom_range(0, 1));
      rf = (i % 3 == 0) ? rv[31] : 1'($urandom_range(0, 1));
      drive(rv, rs, rd, rf);
      @(posedge clk);
      #1;
      check($sformatf("rand_%0d in=%h s=%0d d=%0b f=%0b", i, rv, rs, rd, rf),
            out, ref_shift(rv, int'(rs), rd, rf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
